// File: rtl/spio_uart_pkg.sv
// rtl/spio_uart_pkg.sv - shared constants, state encoding and header helper for the UART TX arbiter
// Contents:
//   HDR_BASE     upper nibble of the frame header byte (0xF0)
//   arb_state_t  arbiter states (IDLE waits for a grant, BODY forwards payload)
//   hdr_byte()   header byte for a granted port id
package spio_uart_pkg;

    localparam logic [7:0] HDR_BASE = 8'hF0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } arb_state_t;

    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return HDR_BASE | {4'h0, id};
    endfunction

endpackage

// File: rtl/spio_uart_tx_arb_if.sv
// rtl/spio_uart_tx_arb_if.sv - requester and transmitter handshake bundle of the UART TX arbiter
// Signals:
//   DATA_IN/LAST_IN/VLD_IN/RDY_OUT  per-port requester byte streams (port i at DATA_IN[8i+7:8i])
//   DATA_OUT/VLD_OUT/RDY_IN         byte stream towards the UART transmitter
//   CTS_IN                          synchronised clear-to-send from the far receiver
//   GRANT_OUT/TRUNC_OUT             current one-hot grant and forced-release pulse
// Modports: slave = arbiter side, master = requester/transmitter side.
interface spio_uart_tx_arb_if #(
    parameter int NUM_PORTS = 4
);
    logic [8*NUM_PORTS-1:0] DATA_IN;
    logic [NUM_PORTS-1:0]   LAST_IN;
    logic [NUM_PORTS-1:0]   VLD_IN;
    logic [NUM_PORTS-1:0]   RDY_OUT;
    logic [7:0]             DATA_OUT;
    logic                   VLD_OUT;
    logic                   RDY_IN;
    logic                   CTS_IN;
    logic [NUM_PORTS-1:0]   GRANT_OUT;
    logic                   TRUNC_OUT;

    modport slave (
        input  DATA_IN, LAST_IN, VLD_IN, RDY_IN, CTS_IN,
        output RDY_OUT, DATA_OUT, VLD_OUT, GRANT_OUT, TRUNC_OUT
    );

    modport master (
        output DATA_IN, LAST_IN, VLD_IN, RDY_IN, CTS_IN,
        input  RDY_OUT, DATA_OUT, VLD_OUT, GRANT_OUT, TRUNC_OUT
    );
endinterface

// File: rtl/spio_uart_rr_pick.sv
// rtl/spio_uart_rr_pick.sv - round-robin picker: first request after the pointer, wrapping
// Ports:
//   req  request vector
//   ptr  index of the last granted port (search starts at ptr+1)
//   gnt  one-hot winner, idx its index, any set when some request is present
module spio_uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Offsets 1..N visit every port once, ending on ptr itself so a lone
    // requester that was granted last time still wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IW'((int'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/spio_uart_tx_arb.sv
// rtl/spio_uart_tx_arb.sv - frames bytes from NUM_PORTS requesters onto one UART transmitter stream
// Ports:
//   CLK_IN      sole clock, rising edge
//   RESET_N_IN  asynchronous active-low reset
//   bus         spio_uart_tx_arb_if slave modport (requester streams, TX stream, CTS, grant, trunc)
// Each grant emits header 0xF0|port followed by the port's bytes until LAST_IN or
// MAX_FRAME_BYTES payload bytes; a truncated frame continues later under a new header.
module spio_uart_tx_arb
    import spio_uart_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int MAX_FRAME_BYTES = 16
) (
    input  logic                 CLK_IN,
    input  logic                 RESET_N_IN,
    spio_uart_tx_arb_if.slave    bus
);

    localparam int IW = $clog2(NUM_PORTS);

    arb_state_t           state_q, state_d;
    logic [7:0]           data_q, data_d;
    logic                 vld_q, vld_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic                 trunc_q, trunc_d;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;

    logic [7:0]           sel_data;
    logic                 sel_last;
    logic                 sel_vld;
    logic                 slot_free;
    logic                 rdy_en;
    logic                 accept;
    logic [7:0]           cnt_inc;

    spio_uart_rr_pick #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_pick (
        .req (bus.VLD_IN),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Mux the granted requester using the one-hot grant register.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        sel_vld  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                sel_data = bus.DATA_IN[8*i +: 8];
                sel_last = bus.LAST_IN[i];
                sel_vld  = bus.VLD_IN[i];
            end
        end
    end

    // The single output register can take a new byte if it is empty or being
    // drained this very cycle.
    assign slot_free = !vld_q || bus.RDY_IN;
    assign rdy_en    = (state_q == ST_BODY) && slot_free && bus.CTS_IN;
    assign accept    = rdy_en && sel_vld;
    assign cnt_inc   = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        trunc_d = 1'b0;

        // Drained unless reloaded below; never dropped while RDY_IN is low.
        if (slot_free) begin
            vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_any && bus.CTS_IN && slot_free) begin
                    data_d  = hdr_byte(4'(pick_idx));
                    vld_d   = 1'b1;
                    cnt_d   = 8'd0;
                    grant_d = pick_gnt;
                    ptr_d   = pick_idx;
                    state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                if (accept) begin
                    data_d = sel_data;
                    vld_d  = 1'b1;
                    cnt_d  = cnt_inc;
                    if (sel_last) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else if (cnt_inc == 8'(MAX_FRAME_BYTES)) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        trunc_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            vld_q   <= 1'b0;
            cnt_q   <= 8'd0;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_PORTS - 1);
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            trunc_q <= trunc_d;
        end
    end

    assign bus.RDY_OUT   = rdy_en ? grant_q : '0;
    assign bus.DATA_OUT  = data_q;
    assign bus.VLD_OUT   = vld_q;
    assign bus.GRANT_OUT = grant_q;
    assign bus.TRUNC_OUT = trunc_q;

endmodule

// File: doc/spio_uart_tx_arb.md
SPIO_UART_TX_ARB -- requirements
Module: spio_uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requester byte streams (2..16).
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 16, payload bytes per grant before forced release (1..255).
REQ-003 SHALL have port CLK_IN  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N_IN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port DATA_IN  input  8*NUM_PORTS  requester bytes, port i at bits [8i+7:8i].
REQ-006 SHALL have port LAST_IN  input  NUM_PORTS  final byte of requester frame.
REQ-007 SHALL have port VLD_IN  input  NUM_PORTS  requester byte valid.
REQ-008 SHALL have port RDY_OUT  output  NUM_PORTS  requester byte accepted when VLD_IN[i]&RDY_OUT[i].
REQ-009 SHALL have port DATA_OUT  output  8  byte to UART transmitter.
REQ-010 SHALL have port VLD_OUT  output  1  DATA_OUT valid.
REQ-011 SHALL have port RDY_IN  input  1  transmitter ready.
REQ-012 SHALL have port CTS_IN  input  1  synchronised clear-to-send from far receiver.
REQ-013 SHALL have port GRANT_OUT  output  NUM_PORTS  one-hot current grant, zero when idle.
REQ-014 SHALL have port TRUNC_OUT  output  1  one-cycle pulse on forced release at MAX_FRAME_BYTES.

Function
REQ-015 SHALL implement states IDLE and BODY.
REQ-016 SHALL keep a single output register (DATA_OUT/VLD_OUT); slot free when VLD_OUT=0 or RDY_IN=1 this cycle.
REQ-017 SHALL, in IDLE with any VLD_IN high, CTS_IN=1 and slot free, grant port round-robin: first requester at index ptr+1, ptr+2, ... wrapping modulo NUM_PORTS; ptr := granted index.
REQ-018 SHALL, on grant, load header 8'hF0|id[3:0] into output register, set VLD_OUT, clear byte count, enter BODY; same cycle, RDY_OUT all zero.
REQ-019 SHALL drive RDY_OUT[g]=1 only in BODY, for granted port g, when slot free and CTS_IN=1; all other RDY_OUT bits 0.
REQ-020 SHALL, on accepted byte, load it into output register next cycle (1-cycle latency) and increment count (8-bit).
REQ-021 SHALL, on accepted byte with LAST_IN[g]=1, return to IDLE and clear GRANT_OUT next cycle.
REQ-022 SHALL, on accepted byte making count equal MAX_FRAME_BYTES without LAST_IN, return to IDLE and pulse TRUNC_OUT; remaining bytes form a new frame with new header.
REQ-023 SHALL, when LAST_IN and MAX reached together, treat as normal end; no TRUNC_OUT.
REQ-024 SHALL hold DATA_OUT stable while VLD_OUT=1 and RDY_IN=0; VLD_OUT never deasserts without acceptance, CTS_IN low notwithstanding.
REQ-025 SHALL, CTS_IN low, start no new header or byte; resume without loss when CTS_IN returns.
REQ-026 SHALL keep grant in BODY while granted VLD_IN is low (no timeout, no pre-emption).
REQ-027 SHALL sustain one byte per cycle when RDY_IN and CTS_IN stay high (back-to-back acceptance).

Reset
REQ-028 SHALL on RESET_N_IN low: state IDLE, VLD_OUT=0, DATA_OUT=8'h00, RDY_OUT=0, GRANT_OUT=0, TRUNC_OUT=0, count=0, ptr=NUM_PORTS-1 (port 0 wins first).
REQ-029 SHALL on reset mid-frame discard output register content and partial frame; no byte emitted after reset until new grant.

Structure
REQ-030 SHALL place header constant 8'hF0, state encoding and header-byte function in shared package spio_uart_pkg.
REQ-031 SHALL implement round-robin selection in sub-module spio_uart_rr_pick (request vector, pointer -> one-hot grant, index, any).

Verification
REQ-032 SHALL cover: port 2 sends 0x11,0x22(LAST), RDY_IN=1, CTS_IN=1 -> DATA_OUT 0xF2,0x11,0x22 on consecutive cycles, GRANT_OUT 4'b0100 then 0.
REQ-033 SHALL cover: ports 0,1,3 continuously request 1-byte frames -> headers 0xF0,0xF1,0xF3,0xF0 in order.
REQ-034 SHALL cover: MAX_FRAME_BYTES=4, port 1 sends 6 bytes 0x01..0x06, LAST on 0x06 -> 0xF1,01,02,03,04, TRUNC_OUT pulse, 0xF1,05,06.
REQ-035 SHALL cover: RDY_IN low 10 cycles with VLD_OUT=1 -> DATA_OUT unchanged, RDY_OUT=0, no byte lost or duplicated.
REQ-036 SHALL cover: CTS_IN low mid-frame for 20 cycles -> pending byte still drains, no new accepts, frame resumes intact.
REQ-037 SHALL cover: RESET_N_IN low mid-frame -> outputs per REQ-028 immediately (asynchronous), next frame starts with header 0xF0 from port 0.
